// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader_pkg
// Description : Shared constants for the instruction-memory program loader:
//               FSM state encoding, default address width, bytes per word.
// Revision    : 1.0 - initial release
// ============================================================================
package imem_loader_pkg;

  // Loader FSM state encoding
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_WRITE   = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  // Default instruction-memory word address width
  localparam int IMEM_ADDR_W = 9;

  // Bytes packed into each instruction word
  localparam int WORD_BYTES = 4;

endpackage : imem_loader_pkg
`default_nettype wire

// File: rtl/imem_loader_byte_packer.sv
`default_nettype none
// ============================================================================
// Module      : byte_packer
// Description : Packs an accepted byte stream little-endian into 32-bit
//               words. Byte n of a word lands in bits 8n+7:8n. word_full
//               flags the accept that completes a word.
// Revision    : 1.0 - initial release
// ============================================================================
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,      // synchronous, active-low
  input  logic        clear,      // restart packing at lane 0
  input  logic        accept,     // a byte is consumed this cycle
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic        word_full
);

  localparam int LANE_W = $clog2(WORD_BYTES);

  logic [LANE_W-1:0] lane;

  // The completing byte is written on the same edge the FSM moves to WRITE,
  // so the full word is visible on the register output during WRITE.
  assign word_full = accept && (lane == LANE_W'(WORD_BYTES - 1));

  // Lane counter and word register; a reset or clear drops any partial word
  always_ff @(posedge clk) begin
    if (!reset) begin
      lane <= '0;
      word <= '0;
    end else if (clear) begin
      lane <= '0;
      word <= '0;
    end else if (accept) begin
      word[lane*8 +: 8] <= data;
      lane              <= lane + LANE_W'(1);
    end
  end

endmodule : byte_packer
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Program loader for the core's instruction memory. Accepts a
//               byte stream, packs it into words, writes them from address 0
//               upward and holds the core in PC reset until the load is done.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int LEN_W  = 10
) (
  input  logic              clk,
  input  logic              reset,       // synchronous, active-low
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              we0,
  output logic [ADDR_W-1:0] wr_addr0,
  output logic [31:0]       wr_din0,
  output logic              resetpc,
  output logic              busy,
  output logic              done
);

  localparam int unsigned MAX_WORDS = 1 << ADDR_W;

  logic [1:0]      state;
  // One bit wider than the address so a full-depth load ends at MAX_WORDS
  // instead of wrapping back to address 0.
  logic [ADDR_W:0] word_cnt;
  logic [ADDR_W:0] len_q;
  logic [ADDR_W:0] len_clamped;
  logic [ADDR_W:0] word_cnt_inc;
  logic            run;
  logic            start_ok;
  logic            accept;
  logic            word_full;
  logic [31:0]     packed_word;

  // Every output is a register or a pure decode of the state register
  assign byte_ready = (state == ST_COLLECT);
  assign we0        = (state == ST_WRITE);
  assign done       = (state == ST_RELEASE);
  assign busy       = (state != ST_IDLE);
  assign resetpc    = run;
  assign wr_addr0   = word_cnt[ADDR_W-1:0];
  assign wr_din0    = packed_word;

  assign start_ok     = (state == ST_IDLE) && start;
  assign accept       = byte_valid && byte_ready;
  assign word_cnt_inc = word_cnt + {{ADDR_W{1'b0}}, 1'b1};

  // Requested length is limited to the memory depth
  always_comb begin
    len_clamped = (ADDR_W+1)'(len);
    if (32'(len) > MAX_WORDS) begin
      len_clamped = (ADDR_W+1)'(MAX_WORDS);
    end
  end

  byte_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .clear     (start_ok),
    .accept    (accept),
    .data      (byte_data),
    .word      (packed_word),
    .word_full (word_full)
  );

  // Loader FSM with word counter, latched length and core-release flag
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= ST_IDLE;
      word_cnt <= '0;
      len_q    <= '0;
      run      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            // Hold the core from the cycle after start, before any write
            run <= 1'b0;
            if (len != '0) begin
              len_q    <= len_clamped;
              word_cnt <= '0;
              state    <= ST_COLLECT;
            end else begin
              state    <= ST_RELEASE;
            end
          end
        end
        ST_COLLECT: begin
          if (word_full) begin
            state <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          word_cnt <= word_cnt_inc;
          if (word_cnt_inc == len_q) begin
            state <= ST_RELEASE;
          end else begin
            state <= ST_COLLECT;
          end
        end
        ST_RELEASE: begin
          run   <= 1'b1;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule : imem_loader
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_loader
// Description : Directed self-checking bench for imem_loader: reset, basic
//               load, gaps and WRITE backpressure, zero length, full depth
//               with clamp, reset mid-load and restart.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  len = '0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = '0;
  logic        byte_ready;
  logic        we0;
  logic [8:0]  wr_addr0;
  logic [31:0] wr_din0;
  logic        resetpc;
  logic        busy;
  logic        done;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;
  int start_cyc = 0;
  int done_cyc  = 0;
  int n_done    = 0;
  logic [8:0]  wa_q[$];
  logic [31:0] wd_q[$];

  imem_loader #(.ADDR_W(9), .LEN_W(10)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .len        (len),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .we0        (we0),
    .wr_addr0   (wr_addr0),
    .wr_din0    (wr_din0),
    .resetpc    (resetpc),
    .busy       (busy),
    .done       (done)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Cycle counter
  always @(posedge clk) cyc <= cyc + 1;

  // Write and done log, sampled mid-cycle
  always @(negedge clk) begin
    if (we0 === 1'b1) begin
      wa_q.push_back(wr_addr0);
      wd_q.push_back(wr_din0);
    end
    if (done === 1'b1) n_done <= n_done + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one byte and hold it until the loader takes it
  task automatic push_byte(input logic [7:0] b, output int waited);
    bit acc = 0;
    bit rdy;
    waited = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    while (!acc && waited < 200) begin
      @(negedge clk);
      rdy = byte_ready;
      @(posedge clk);
      #1;
      waited++;
      if (rdy) acc = 1;
    end
    if (!acc) check("byte_accept_timeout", 0, 1);
  endtask

  task automatic push(input logic [7:0] b);
    int w;
    push_byte(b, w);
  endtask

  task automatic do_start(input logic [9:0] l);
    @(posedge clk);
    #1;
    wa_q.delete();
    wd_q.delete();
    n_done    = 0;
    start     = 1'b1;
    len       = l;
    start_cyc = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit seen = 0;
    for (int t = 0; t < budget && !seen; t++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen     = 1;
        done_cyc = cyc;
      end
    end
    check("done_seen", 64'(seen), 1);
    if (seen) begin
      check("resetpc_in_done", 64'(resetpc), 0);
      @(negedge clk);
      check("resetpc_after_done", 64'(resetpc), 1);
      check("done_single", 64'(done), 0);
      check("busy_after_done", 64'(busy), 0);
    end
  endtask

  initial begin
    int w;
    int aerr;
    int derr;
    logic [31:0] expw;

    // ---------------- reset and idle ----------------
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_resetpc", 64'(resetpc), 0);
    check("rst_byte_ready", 64'(byte_ready), 0);
    check("rst_we0", 64'(we0), 0);
    check("rst_busy", 64'(busy), 0);
    check("rst_done", 64'(done), 0);
    check("rst_wr_addr0", 64'(wr_addr0), 0);
    check("rst_wr_din0", 64'(wr_din0), 0);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_resetpc", 64'(resetpc), 0);
    check("idle_byte_ready", 64'(byte_ready), 0);
    check("idle_no_writes", 64'(wa_q.size()), 0);

    // ---------------- basic load, len=2 ----------------
    do_start(10'd2);
    check("basic_busy", 64'(busy), 1);
    push(8'h13); push(8'h00); push(8'h00); push(8'h00);
    push(8'h93); push(8'h00); push(8'h10); push(8'h00);
    byte_valid = 1'b0;
    wait_done(10);
    check("basic_latency", 64'(done_cyc - start_cyc), 11);
    check("basic_nwrites", 64'(wa_q.size()), 2);
    if (wa_q.size() == 2) begin
      check("basic_addr0", 64'(wa_q[0]), 0);
      check("basic_data0", 64'(wd_q[0]), 64'h0000_0013);
      check("basic_addr1", 64'(wa_q[1]), 1);
      check("basic_data1", 64'(wd_q[1]), 64'h0010_0093);
    end
    check("basic_ndone", 64'(n_done), 1);

    // ---------------- zero length ----------------
    do_start(10'd0);
    wait_done(5);
    check("zero_latency", 64'(done_cyc - start_cyc), 1);
    check("zero_nwrites", 64'(wa_q.size()), 0);

    // ---------------- gaps and WRITE backpressure, len=2 ----------------
    do_start(10'd2);
    check("bp_resetpc_held", 64'(resetpc), 0);
    push(8'hEF); push(8'hBE);
    byte_valid = 1'b0;
    @(negedge clk);
    check("bp_ready_in_gap", 64'(byte_ready), 1);
    repeat (3) @(posedge clk);
    #1;
    push(8'hAD); push(8'hDE);
    byte_data  = 8'h5A;
    byte_valid = 1'b1;
    @(negedge clk);
    check("bp_ready_in_write", 64'(byte_ready), 0);
    check("bp_we0", 64'(we0), 1);
    check("bp_wr_addr0", 64'(wr_addr0), 0);
    check("bp_wr_din0", 64'(wr_din0), 64'hDEAD_BEEF);
    push_byte(8'h5A, w);
    check("bp_accept_next_collect", 64'(w), 1);
    push(8'h01); push(8'h02); push(8'h03);
    byte_valid = 1'b0;
    wait_done(10);
    check("bp_nwrites", 64'(wa_q.size()), 2);
    if (wa_q.size() == 2) begin
      check("bp_word0", 64'(wd_q[0]), 64'hDEAD_BEEF);
      check("bp_addr1", 64'(wa_q[1]), 1);
      check("bp_word1", 64'(wd_q[1]), 64'h0302_015A);
    end

    // ---------------- full depth, len=600 clamps to 512 ----------------
    do_start(10'd600);
    for (int i = 0; i < 2048; i++) push(8'(i));
    byte_valid = 1'b0;
    wait_done(10);
    check("full_nwrites", 64'(wa_q.size()), 512);
    aerr = 0;
    derr = 0;
    for (int i = 0; i < wa_q.size(); i++) begin
      expw = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
      if (wa_q[i] !== 9'(i)) aerr++;
      if (wd_q[i] !== expw) derr++;
    end
    check("full_addr_errs", 64'(aerr), 0);
    check("full_data_errs", 64'(derr), 0);
    check("full_ndone", 64'(n_done), 1);

    // ---------------- reset mid-load and restart ----------------
    do_start(10'd4);
    for (int i = 0; i < 10; i++) push(8'(8'h40 + i));
    byte_valid = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("mid_busy", 64'(busy), 0);
    check("mid_resetpc", 64'(resetpc), 0);
    check("mid_byte_ready", 64'(byte_ready), 0);
    check("mid_we0", 64'(we0), 0);
    check("mid_wr_addr0", 64'(wr_addr0), 0);
    check("mid_wr_din0", 64'(wr_din0), 0);
    check("mid_nwrites", 64'(wa_q.size()), 2);
    do_start(10'd1);
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    byte_valid = 1'b0;
    wait_done(10);
    check("restart_nwrites", 64'(wa_q.size()), 1);
    if (wa_q.size() == 1) begin
      check("restart_addr", 64'(wa_q[0]), 0);
      check("restart_data", 64'(wd_q[0]), 64'h4433_2211);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // Global time bound
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_imem_loader
`default_nettype wire
